pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 44 ++++
 rtl/pipe_stage_reg_entry.sv | 39 +++
 rtl/pipe_stage_reg.sv | 169 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register slice:
// reset/exception PCs, ExcCode width and encodings, entry layout.
package pipe_stage_reg_pkg;

    localparam int EXC_W = 5;

    localparam logic [31:0] PC_INIT_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;

    typedef enum logic [EXC_W-1:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_IBE  = 5'd6,
        EXC_DBE  = 5'd7,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_CPU  = 5'd11,
        EXC_OV   = 5'd12,
        EXC_TR   = 5'd13
    } exc_code_e;

    typedef struct packed {
        logic [31:0]      instr;
        logic [31:0]      pc;
        logic [EXC_W-1:0] exc;
        logic             bd;
    } entry_t;

    // Empty slot contents: zero instruction, no exception, given PC.
    function automatic entry_t bubble(input logic [31:0] pc);
        entry_t e;
        e.instr = 32'h0;
        e.pc    = pc;
        e.exc   = EXC_INT;
        e.bd    = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One storage slot of the stage register: valid bit plus fields,
// with synchronous reset, clear and load.
module pipe_entry
    import pipe_stage_reg_pkg::*;
#(
    parameter int          SIDE_W  = 8,
    parameter logic [31:0] PC_INIT = PC_INIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              d_valid,
    input  entry_t            d,
    input  logic [SIDE_W-1:0] d_side,
    output logic              q_valid,
    output entry_t            q,
    output logic [SIDE_W-1:0] q_side
);

    logic go_idle;

    // Loading an invalid item parks the slot in its idle state so that
    // no stale instruction lingers behind valid=0.
    assign go_idle = !reset || clear || (load && !d_valid);

    always_ff @(posedge clk) begin
        if (go_idle) begin
            q_valid <= 1'b0;
            q       <= bubble(PC_INIT);
            q_side  <= '0;
        end else if (load) begin
            q_valid <= 1'b1;
            q       <= d;
            q_side  <= d_side;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with skid buffer, flush, exception entry
// and a saturating stall counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int          SIDE_W    = 8,
    parameter logic [31:0] PC_INIT   = PC_INIT_DEF,
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              req,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic [SIDE_W-1:0] out_side,
    output logic [CNT_W-1:0]  stall_cnt
);

    entry_t            in_ent;
    entry_t            main_q;
    entry_t            skid_q;
    entry_t            main_d;
    logic              main_valid;
    logic              skid_valid;
    logic [SIDE_W-1:0] main_side;
    logic [SIDE_W-1:0] skid_side;
    logic [SIDE_W-1:0] main_d_side;
    logic              main_d_valid;
    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic              in_ready_nxt;
    logic              xfer;
    logic              do_req;
    logic              do_clr;
    logic              do_pass;
    logic              do_hold;
    logic              stalled;

    assign in_ent.instr = in_instr;
    assign in_ent.pc    = in_pc;
    assign in_ent.exc   = in_exc;
    assign in_ent.bd    = in_bd;

    assign xfer    = in_valid && in_ready;
    assign stalled = main_valid && !out_ready;

    // Mutually exclusive cycle modes, req over clr over normal flow.
    assign do_req  = req;
    assign do_clr  = clr && !req;
    assign do_pass = !req && !clr && !stalled;
    assign do_hold = !req && !clr && stalled;

    always_comb begin
        main_load    = 1'b0;
        main_clear   = 1'b0;
        main_d_valid = 1'b0;
        main_d       = bubble(PC_INIT);
        main_d_side  = '0;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        in_ready_nxt = !skid_valid;
        unique case (1'b1)
            do_req: begin
                main_load    = 1'b1;
                main_d_valid = 1'b1;
                main_d       = bubble(EXC_ENTRY);
                skid_clear   = 1'b1;
                in_ready_nxt = 1'b1;
            end
            do_clr: begin
                main_clear   = 1'b1;
                skid_clear   = 1'b1;
                in_ready_nxt = 1'b1;
            end
            do_pass: begin
                main_load = 1'b1;
                if (skid_valid) begin
                    main_d_valid = 1'b1;
                    main_d       = skid_q;
                    main_d_side  = skid_side;
                end else if (xfer) begin
                    main_d_valid = 1'b1;
                    main_d       = in_ent;
                    main_d_side  = in_side;
                end
                skid_clear   = 1'b1;
                in_ready_nxt = 1'b1;
            end
            do_hold: begin
                skid_load    = xfer;
                in_ready_nxt = !(skid_valid || xfer);
            end
            default: begin
                in_ready_nxt = !skid_valid;
            end
        endcase
    end

    pipe_entry #(
        .SIDE_W  (SIDE_W),
        .PC_INIT (PC_INIT)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .clear   (main_clear),
        .load    (main_load),
        .d_valid (main_d_valid),
        .d       (main_d),
        .d_side  (main_d_side),
        .q_valid (main_valid),
        .q       (main_q),
        .q_side  (main_side)
    );

    pipe_entry #(
        .SIDE_W  (SIDE_W),
        .PC_INIT (PC_INIT)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear   (skid_clear),
        .load    (skid_load),
        .d_valid (1'b1),
        .d       (in_ent),
        .d_side  (in_side),
        .q_valid (skid_valid),
        .q       (skid_q),
        .q_side  (skid_side)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= in_ready_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || req || clr) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid = main_valid;
    assign out_instr = main_q.instr;
    assign out_pc    = main_q.pc;
    assign out_exc   = main_q.exc;
    assign out_bd    = main_q.bd;
    assign out_side  = main_side;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// A second instance with a 4-bit counter covers saturation.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        req;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  in_exc;
    logic        in_bd;
    logic [7:0]  in_side;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [4:0]  out_exc;
    logic        out_bd;
    logic [7:0]  out_side;
    logic [15:0] stall_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_instr;
    logic [31:0] s_out_pc;
    logic [4:0]  s_out_exc;
    logic        s_out_bd;
    logic [7:0]  s_out_side;
    logic [3:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .SIDE_W (8),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .req       (req),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_exc    (in_exc),
        .in_bd     (in_bd),
        .in_side   (in_side),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_exc   (out_exc),
        .out_bd    (out_bd),
        .out_side  (out_side),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_reg #(
        .SIDE_W (8),
        .CNT_W  (4)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .req       (req),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_exc    (in_exc),
        .in_bd     (in_bd),
        .in_side   (in_side),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_instr (s_out_instr),
        .out_pc    (s_out_pc),
        .out_exc   (s_out_exc),
        .out_bd    (s_out_bd),
        .out_side  (s_out_side),
        .stall_cnt (s_stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        req      = 1'b0;
        clr      = 1'b0;
        in_instr = 32'h0;
        in_pc    = 32'h0;
        in_exc   = 5'h0;
        in_bd    = 1'b0;
        in_side  = 8'h0;
    endtask

    task automatic put(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] exc, input logic bd,
                       input logic [7:0] side);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        in_exc   = exc;
        in_bd    = bd;
        in_side  = side;
    endtask

    task automatic flush();
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        out_ready = 1'b0;
        reset = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_pc !== 32'h3000) begin
            errors++;
            $display("FAIL rst_pc: got %h want 00003000", out_pc);
        end
        checks++;
        if (out_instr !== 32'h0) begin
            errors++;
            $display("FAIL rst_instr: got %h want 0", out_instr);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ready: got %b want 0", in_ready);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_stall: got %0d want 0", stall_cnt);
        end
        reset = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_streaming();
        flush();
        out_ready = 1'b1;
        put(32'h3000, 32'h0010_0093, 5'd0, 1'b0, 8'h11);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h3000 ||
            out_instr !== 32'h0010_0093 || out_side !== 8'h11) begin
            errors++;
            $display("FAIL stream_a: got v=%b pc=%h i=%h s=%h want 1 3000 00100093 11",
                     out_valid, out_pc, out_instr, out_side);
        end
        put(32'h3004, 32'h0020_8113, 5'd10, 1'b1, 8'h22);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h3004 || out_exc !== 5'd10 ||
            out_bd !== 1'b1 || out_side !== 8'h22) begin
            errors++;
            $display("FAIL stream_b: got v=%b pc=%h e=%0d bd=%b s=%h want 1 3004 10 1 22",
                     out_valid, out_pc, out_exc, out_bd, out_side);
        end
        put(32'h3008, 32'h0031_0193, 5'd4, 1'b0, 8'h33);
        step();
        checks++;
        if (out_pc !== 32'h3008 || out_instr !== 32'h0031_0193 ||
            out_exc !== 5'd4 || out_bd !== 1'b0) begin
            errors++;
            $display("FAIL stream_c: got pc=%h i=%h e=%0d bd=%b want 3008 00310193 4 0",
                     out_pc, out_instr, out_exc, out_bd);
        end
        idle();
        step();
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
            errors++;
            $display("FAIL stream_drain: got v=%b i=%h want 0 0", out_valid, out_instr);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stream_stall: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        flush();
        out_ready = 1'b0;
        put(32'h3100, 32'hAAAA_0001, 5'd0, 1'b0, 8'hA1);
        step();
        checks++;
        if (out_pc !== 32'h3100 || in_ready !== 1'b1 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL bp_first: got pc=%h rdy=%b cnt=%0d want 3100 1 0",
                     out_pc, in_ready, stall_cnt);
        end
        put(32'h3104, 32'hBBBB_0002, 5'd0, 1'b0, 8'hB2);
        step();
        checks++;
        if (in_ready !== 1'b0 || out_pc !== 32'h3100 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bp_skid: got rdy=%b pc=%h cnt=%0d want 0 3100 1",
                     in_ready, out_pc, stall_cnt);
        end
        idle();
        step();
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL bp_cnt2: got %0d want 2", stall_cnt);
        end
        step();
        checks++;
        if (stall_cnt !== 16'd3 || out_instr !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL bp_cnt3: got cnt=%0d i=%h want 3 aaaa0001",
                     stall_cnt, out_instr);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h3104 ||
            out_instr !== 32'hBBBB_0002 || out_side !== 8'hB2) begin
            errors++;
            $display("FAIL bp_drain_b: got v=%b pc=%h i=%h s=%h want 1 3104 bbbb0002 b2",
                     out_valid, out_pc, out_instr, out_side);
        end
        checks++;
        if (in_ready !== 1'b1 || stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL bp_drain_rdy: got rdy=%b cnt=%0d want 1 3",
                     in_ready, stall_cnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        flush();
        out_ready = 1'b1;
        put(32'h3600, 32'h0000_3600, 5'd0, 1'b0, 8'h60);
        step();
        out_ready = 1'b0;
        put(32'h3604, 32'h0000_3604, 5'd0, 1'b0, 8'h64);
        step();
        checks++;
        if (out_pc !== 32'h3600 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: got pc=%h rdy=%b want 3600 0", out_pc, in_ready);
        end
        put(32'h3608, 32'h0000_3608, 5'd0, 1'b0, 8'h68);
        out_ready = 1'b1;
        step();
        checks++;
        if (out_pc !== 32'h3604 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_skid_out: got pc=%h v=%b want 3604 1", out_pc, out_valid);
        end
        step();
        checks++;
        if (out_pc !== 32'h3608 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_third: got pc=%h v=%b want 3608 1", out_pc, out_valid);
        end
        idle();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty: got %b want 0", out_valid);
        end
    endtask

    task automatic test_exception();
        flush();
        out_ready = 1'b0;
        put(32'h3200, 32'h1111_1111, 5'd3, 1'b1, 8'h77);
        step();
        put(32'h3204, 32'h2222_2222, 5'd5, 1'b1, 8'h88);
        step();
        idle();
        req = 1'b1;
        step();
        req = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4180 || out_instr !== 32'h0) begin
            errors++;
            $display("FAIL exc_entry: got v=%b pc=%h i=%h want 1 4180 0",
                     out_valid, out_pc, out_instr);
        end
        checks++;
        if (out_exc !== 5'd0 || out_bd !== 1'b0 || out_side !== 8'h0) begin
            errors++;
            $display("FAIL exc_fields: got e=%0d bd=%b s=%h want 0 0 0",
                     out_exc, out_bd, out_side);
        end
        checks++;
        if (in_ready !== 1'b1 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL exc_ctrl: got rdy=%b cnt=%0d want 1 0", in_ready, stall_cnt);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL exc_skid_gone: got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        flush();
        out_ready = 1'b0;
        put(32'h3300, 32'h3333_3333, 5'd0, 1'b0, 8'h33);
        step();
        put(32'h3304, 32'hDEAD_0000, 5'd0, 1'b0, 8'hDD);
        clr = 1'b1;
        step();
        idle();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h3000 || out_instr !== 32'h0) begin
            errors++;
            $display("FAIL flush_state: got v=%b pc=%h i=%h want 0 3000 0",
                     out_valid, out_pc, out_instr);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready: got %b want 1", in_ready);
        end
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || out_instr === 32'hDEAD_0000) begin
            errors++;
            $display("FAIL flush_dropped: got v=%b i=%h want 0 0", out_valid, out_instr);
        end
    endtask

    task automatic test_reset_midstall();
        flush();
        out_ready = 1'b0;
        put(32'h3400, 32'h4444_0000, 5'd0, 1'b0, 8'h40);
        step();
        put(32'h3404, 32'h4444_0004, 5'd0, 1'b0, 8'h44);
        step();
        idle();
        reset = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h3000 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: got v=%b pc=%h rdy=%b want 0 3000 0",
                     out_valid, out_pc, in_ready);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_cnt: got %0d want 0", stall_cnt);
        end
        reset = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release: got rdy=%b v=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_saturation();
        flush();
        out_ready = 1'b0;
        put(32'h3500, 32'h5555_5555, 5'd0, 1'b0, 8'h55);
        step();
        idle();
        repeat (14) step();
        checks++;
        if (s_stall_cnt !== 4'd14) begin
            errors++;
            $display("FAIL sat_14: got %0d want 14", s_stall_cnt);
        end
        step();
        checks++;
        if (s_stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_15: got %0d want 15", s_stall_cnt);
        end
        repeat (5) step();
        checks++;
        if (s_stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: got %0d want 15", s_stall_cnt);
        end
        checks++;
        if (stall_cnt !== 16'd20) begin
            errors++;
            $display("FAIL sat_wide: got %0d want 20", stall_cnt);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (s_stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL sat_clr: got %0d want 0", s_stall_cnt);
        end
    endtask

    initial begin
        idle();
        reset     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_back_to_back();
        test_exception();
        test_flush();
        test_reset_midstall();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
